pulse_oneshot: RTL and testbench



---
 rtl/pulse_oneshot.sv | 129 ++++++++++++
 tb/tb_pulse_oneshot.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pulse_oneshot.sv
// Per-channel leading-edge one-shot with programmable dead time and sticky miss flags.
// Define ONESHOT_SYNC_EN to pass each channel through a 2-flop synchronizer first.
module pulse_oneshot #(
    parameter int unsigned WIDTH   = 48,
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             clr_miss,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] armed,
    output logic [WIDTH-1:0] miss
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        HOLD     = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] rise;

    state_t           state      [WIDTH];
    state_t           state_next [WIDTH];
    logic [CNT_W-1:0] cnt        [WIDTH];
    logic [CNT_W-1:0] cnt_next   [WIDTH];
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] armed_next;
    logic [WIDTH-1:0] miss_next;

`ifdef ONESHOT_SYNC_EN
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Two-stage synchronizer for asynchronous discriminator lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d <= '0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                state[i] <= ARMED;
                cnt[i]   <= '0;
            end
            out   <= '0;
            armed <= '1;
            miss  <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
            out   <= out_next;
            armed <= armed_next;
            miss  <= miss_next;
        end
    end

    // Per-channel next state; ARMED fires on level since it is only entered with s low
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out_next   = '0;
        armed_next = '0;
        miss_next  = miss & ~{WIDTH{clr_miss}};
        for (int i = 0; i < int'(WIDTH); i++) begin
            case (state[i])
                ARMED: begin
                    if (s[i]) begin
                        out_next[i]   = 1'b1;
                        cnt_next[i]   = HOLD_LOAD;
                        state_next[i] = HOLD;
                    end
                end
                HOLD: begin
                    if (cnt[i] != '0) begin
                        cnt_next[i] = cnt[i] - CNT_W'(1);
                    end else if (s[i]) begin
                        state_next[i] = WAIT_LOW;
                    end else begin
                        state_next[i] = ARMED;
                    end
                end
                WAIT_LOW: begin
                    if (!s[i]) begin
                        state_next[i] = ARMED;
                    end
                end
                default: begin
                    state_next[i] = ARMED;
                end
            endcase
            if (rise[i] && (state[i] != ARMED)) begin
                miss_next[i] = 1'b1;
            end
            armed_next[i] = (state_next[i] == ARMED);
        end
    end

endmodule

// File: tb/tb_pulse_oneshot.sv
// Self-checking bench for pulse_oneshot: table-driven per-channel traces plus
// hand-written sequences for simultaneous firing and reset during HOLD.
module tb_pulse_oneshot;

    localparam int unsigned W = 48;
`ifdef ONESHOT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int   ch;
        logic in;
        logic clr;
        logic o;
        logic a;
        logic m;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_v;
    logic         clr_v;
    logic [W-1:0] out_v;
    logic [W-1:0] armed_v;
    logic [W-1:0] miss_v;

    int checks;
    int errors;
    vec_t tab[$];

    pulse_oneshot #(.WIDTH(W), .HOLDOFF(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_v),
        .clr_miss (clr_v),
        .out      (out_v),
        .armed    (armed_v),
        .miss     (miss_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic [W-1:0] v, input logic c);
        @(negedge clk);
        in_v  = v;
        clr_v = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int ch, input logic i, input logic c, input logic o,
                       input logic a, input logic m);
        vec_t e;
        e.ch = ch; e.in = i; e.clr = c; e.o = o; e.a = a; e.m = m;
        tab.push_back(e);
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] eo;
        logic [W-1:0] ea;
        logic [W-1:0] em;
        logic         c;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        in_v   = '0;
        clr_v  = 1'b0;

        // Gate held high for 10 cycles on ch0: one strobe, armed back after it drops
        for (int k = 0; k < 10; k++) add(0, 1'b1, 1'b0, k == 0, 1'b0, 1'b0);
        add(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // ch5 single-cycle pulses every HOLDOFF+1 cycles: all strobed, no miss
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 5; k++) add(5, k == 0, 1'b0, k == 0, k == 4, 1'b0);
        // ch5 pulses every 3 cycles: every other one strobed, miss sets
        add(5, 1, 0, 1, 0, 0); add(5, 0, 0, 0, 0, 0); add(5, 0, 0, 0, 0, 0);
        add(5, 1, 0, 0, 0, 1); add(5, 0, 0, 0, 1, 1); add(5, 0, 0, 0, 1, 1);
        add(5, 1, 0, 1, 0, 1); add(5, 0, 0, 0, 0, 1); add(5, 0, 0, 0, 0, 1);
        add(5, 1, 0, 0, 0, 1); add(5, 0, 0, 0, 1, 1); add(5, 0, 1, 0, 1, 0);
        add(5, 0, 0, 0, 1, 0);
        // ch0 stretched gate with a retrigger glitch inside HOLD, then set/clear race
        add(0, 1, 0, 1, 0, 0); add(0, 1, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        for (int k = 0; k < 16; k++) add(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(0, 0, 0, 0, 1, 1);
        add(0, 1, 1, 1, 0, 0); add(0, 0, 0, 0, 0, 0); add(0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 1, 1); add(0, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0);

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 0, out_v, '0);
        check("rst_armed", 0, armed_v, '1);
        check("rst_miss", 0, miss_v, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step('0, 1'b0);
        check("idle_out", 0, out_v, '0);
        check("idle_armed", 0, armed_v, '1);

        // Table replay; s-domain expectations shifted by synchronizer latency
        for (int j = 0; j < tab.size() + LAT; j++) begin
            v = '0;
            if (j < tab.size()) v[tab[j].ch] = tab[j].in;
            c = (j >= LAT) ? tab[j - LAT].clr : 1'b0;
            step(v, c);
            if (j >= LAT) begin
                eo = '0; ea = '1; em = '0;
                eo[tab[j - LAT].ch] = tab[j - LAT].o;
                ea[tab[j - LAT].ch] = tab[j - LAT].a;
                em[tab[j - LAT].ch] = tab[j - LAT].m;
                check("tab_out", j - LAT, out_v, eo);
                check("tab_armed", j - LAT, armed_v, ea);
                check("tab_miss", j - LAT, miss_v, em);
            end
        end

        // All channels rise together
        for (int t = 0; t <= LAT + 5; t++) begin
            step((t == 0) ? {W{1'b1}} : {W{1'b0}}, 1'b0);
            eo = (t == LAT) ? {W{1'b1}} : {W{1'b0}};
            ea = (t >= LAT && t <= LAT + 3) ? {W{1'b0}} : {W{1'b1}};
            check("all_out", t, out_v, eo);
            check("all_armed", t, armed_v, ea);
        end
        check("all_miss", 0, miss_v, '0);

        // ch3 fires, a second pulse lands in HOLD, then reset hits mid-HOLD
        for (int t = 0; t <= LAT + 2; t++) begin
            v = '0;
            v[3] = (t == 0 || t == 2);
            step(v, 1'b0);
        end
        em = '0; em[3] = 1'b1;
        check("pre_rst_miss", 0, miss_v, em);
        ea = '1; ea[3] = 1'b0;
        check("pre_rst_armed", 0, armed_v, ea);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", 0, out_v, '0);
        check("mid_rst_armed", 0, armed_v, '1);
        check("mid_rst_miss", 0, miss_v, '0);
        @(negedge clk);
        in_v  = '0;
        rst_n = 1'b1;
        step('0, 1'b0);
        check("post_rst_armed", 0, armed_v, '1);
        for (int t = 0; t <= LAT + 1; t++) begin
            v = '0;
            v[3] = (t == 0);
            step(v, 1'b0);
            eo = '0;
            eo[3] = (t == LAT);
            check("post_rst_out", t, out_v, eo);
        end
        repeat (6) step('0, 1'b0);
        check("final_armed", 0, armed_v, '1);
        check("final_miss", 0, miss_v, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
